// File: rtl/mult_ctrl.sv
// Control FSM for the 8-bit shift-add multiplier datapath.
// Sequences LOAD -> MULT (up to WIDTH shift-add cycles) -> STORE -> DONE, with an
// optional early exit once the multiplier shift register has drained to zero.
// Strobes, busy and done are registered copies of the next-state decode, so they
// always equal the decode of the state register and never depend on start or rq
// combinationally.
module mult_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1,
    parameter int unsigned OPS_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH-1:0]         rq,
    output logic                     em,
    output logic                     ra,
    output logic                     rrq,
    output logic                     rrp,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH):0]   iter,
    output logic [OPS_W-1:0]         ops_count
);

    localparam int unsigned ITER_W = $clog2(WIDTH) + 1;
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MULT  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state, state_d;
    logic [ITER_W-1:0] iter_d;
    logic [OPS_W-1:0]  ops_d;
    logic              em_d, ra_d, rrq_d, rrp_d, busy_d, done_d;

    // Next-state, iteration and operation-count logic.
    always_comb begin
        state_d = IDLE;
        iter_d  = iter;
        ops_d   = ops_count;
        case (state)
            IDLE: begin
                state_d = start ? LOAD : IDLE;
            end
            LOAD: begin
                state_d = MULT;
                iter_d  = '0;
            end
            MULT: begin
                // rq == 0 means every remaining addend is zero: A already holds the product.
                if (iter == LAST_ITER || (EARLY_EXIT && rq == '0)) begin
                    state_d = STORE;
                end else begin
                    state_d = MULT;
                    iter_d  = iter + 1'b1;
                end
            end
            STORE: begin
                state_d = DONE;
                ops_d   = ops_count + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode of the next state; registering it yields a clean decode of the
    // state register one edge later.
    always_comb begin
        em_d   = 1'b0;
        ra_d   = 1'b0;
        rrq_d  = 1'b0;
        rrp_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            IDLE: begin
                ra_d = 1'b1;
            end
            LOAD: begin
                ra_d   = 1'b1;
                rrq_d  = 1'b1;
                rrp_d  = 1'b1;
                busy_d = 1'b1;
            end
            MULT: begin
                busy_d = 1'b1;
            end
            STORE: begin
                em_d   = 1'b1;
                busy_d = 1'b1;
            end
            DONE: begin
                ra_d   = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                ra_d = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs; reset forces IDLE outputs immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            iter      <= '0;
            ops_count <= '0;
            em        <= 1'b0;
            ra        <= 1'b1;
            rrq       <= 1'b0;
            rrp       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            iter      <= iter_d;
            ops_count <= ops_d;
            em        <= em_d;
            ra        <= ra_d;
            rrq       <= rrq_d;
            rrp       <= rrp_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Testbench for mult_ctrl: two controllers (early exit on / off), each driving a
// behavioural shift-add datapath. Stimulus pushes expected results into a per-unit
// queue; a monitor pops and compares whenever a done pulse appears.
module tb_mult_ctrl;

    typedef struct {
        int          cyc;
        logic [15:0] m;
        logic [15:0] ops;
        logic [3:0]  it;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        start_s [2];
    logic [7:0]  p_s     [2];
    logic [7:0]  q_s     [2];
    logic [7:0]  rq_s    [2];
    logic        em_s    [2];
    logic        ra_s    [2];
    logic        rrq_s   [2];
    logic        rrp_s   [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic [3:0]  iter_s  [2];
    logic [15:0] ops_s   [2];

    logic [15:0] acc_s [2];
    logic [15:0] rp_s  [2];
    logic [15:0] m_s   [2];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_ops [2];
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mult_ctrl u_ee (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s[0]),
        .rq        (rq_s[0]),
        .em        (em_s[0]),
        .ra        (ra_s[0]),
        .rrq       (rrq_s[0]),
        .rrp       (rrp_s[0]),
        .busy      (busy_s[0]),
        .done      (done_s[0]),
        .iter      (iter_s[0]),
        .ops_count (ops_s[0])
    );

    mult_ctrl #(.EARLY_EXIT(1'b0)) u_ne (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s[1]),
        .rq        (rq_s[1]),
        .em        (em_s[1]),
        .ra        (ra_s[1]),
        .rrq       (rrq_s[1]),
        .rrp       (rrp_s[1]),
        .busy      (busy_s[1]),
        .done      (done_s[1]),
        .iter      (iter_s[1]),
        .ops_count (ops_s[1])
    );

    // Behavioural datapath (no reset): A accumulates RP when RQ[0], RQ/RP shift.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ra_s[i]) acc_s[i] <= 16'd0;
            else if (rq_s[i][0]) acc_s[i] <= acc_s[i] + rp_s[i];
            if (rrq_s[i]) rq_s[i] <= q_s[i];
            else rq_s[i] <= rq_s[i] >> 1;
            if (rrp_s[i]) rp_s[i] <= {8'd0, p_s[i]};
            else rp_s[i] <= rp_s[i] << 1;
            if (em_s[i]) m_s[i] <= acc_s[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: on every done pulse pop the next expectation for that unit.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done_s[i] === 1'b1) begin
                exp_t e;
                int   sz;
                sz = (i == 0) ? q0.size() : q1.size();
                if (sz == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: unit %0d pulsed done with nothing pending, required none (t=%0t)",
                             i, $time);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else e = q1.pop_front();
                    check($sformatf("u%0d_done_cycle", i), cyc, e.cyc);
                    check($sformatf("u%0d_product", i), {16'd0, m_s[i]}, {16'd0, e.m});
                    check($sformatf("u%0d_ops_count", i), {16'd0, ops_s[i]}, {16'd0, e.ops});
                    check($sformatf("u%0d_iter", i), {28'd0, iter_s[i]}, {28'd0, e.it});
                    check($sformatf("u%0d_done_strobes", i),
                          {26'd0, ra_s[i], em_s[i], rrq_s[i], rrp_s[i], busy_s[i], done_s[i]},
                          32'b100001);
                end
            end
        end
    end

    task automatic push(input int i, input int dcyc, input logic [15:0] m, input logic [3:0] it);
        exp_t e;
        exp_ops[i]++;
        e.cyc = dcyc;
        e.m   = m;
        e.ops = 16'(exp_ops[i]);
        e.it  = it;
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Called at a negedge with the unit idle; start is sampled at the next posedge.
    task automatic issue(input int i, input logic [7:0] p, input logic [7:0] q,
                         input logic [15:0] m, input int lat, input logic [3:0] it);
        p_s[i]     = p;
        q_s[i]     = q;
        start_s[i] = 1'b1;
        push(i, cyc + lat, m, it);
        @(negedge clk);
        start_s[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d/%0d results still pending, required 0/0",
                     q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int n0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            p_s[i]     = 8'd0;
            q_s[i]     = 8'd0;
            exp_ops[i] = 0;
        end
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d_reset_strobes", i),
                  {26'd0, ra_s[i], em_s[i], rrq_s[i], rrp_s[i], busy_s[i], done_s[i]}, 32'b100000);
            check($sformatf("u%0d_reset_iter", i), {28'd0, iter_s[i]}, 32'd0);
            check($sformatf("u%0d_reset_ops", i), {16'd0, ops_s[i]}, 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Early-exit unit. Latency = 3 + MULT cycles; MULT cycles = bit length of Q + 1, capped at 8.
        issue(0, 8'd13,  8'h0D, 16'd169,   8,  4'd4);  // rq=13,6,3,1,0: five MULT cycles
        drain();
        issue(0, 8'd255, 8'hFF, 16'hFE01,  11, 4'd7);
        drain();
        issue(0, 8'd200, 8'h00, 16'd0,     4,  4'd0);
        drain();
        issue(0, 8'd200, 8'h01, 16'd200,   5,  4'd1);
        drain();
        issue(0, 8'd3,   8'h80, 16'd384,   11, 4'd7);
        drain();

        // No-early-exit unit always runs eight MULT cycles.
        issue(1, 8'd5,   8'h01, 16'd5,     11, 4'd7);
        drain();

        // start held high: one accepted operation per 12-cycle round trip.
        n0 = cyc;
        p_s[0]     = 8'd255;
        q_s[0]     = 8'hFF;
        start_s[0] = 1'b1;
        push(0, n0 + 11, 16'hFE01, 4'd7);
        push(0, n0 + 23, 16'hFE01, 4'd7);
        repeat (13) @(negedge clk);
        start_s[0] = 1'b0;
        drain();

        // start pulses in MULT and in DONE are ignored.
        n0 = cyc;
        p_s[0]     = 8'd3;
        q_s[0]     = 8'h80;
        start_s[0] = 1'b1;
        push(0, n0 + 11, 16'd384, 4'd7);
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (6) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("ignored_start_busy", {31'd0, busy_s[0]}, 32'd0);
        check("ignored_start_ops", {16'd0, ops_s[0]}, 32'd8);
        drain();

        // Reset during the 4th MULT cycle (cycle 5) of a full-length operation.
        p_s[0]     = 8'd255;
        q_s[0]     = 8'hFF;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy_s[0]}, 32'd1);
        rst = 1'b1;
        #1;
        check("midop_reset_strobes",
              {26'd0, ra_s[0], em_s[0], rrq_s[0], rrp_s[0], busy_s[0], done_s[0]}, 32'b100000);
        check("midop_reset_iter", {28'd0, iter_s[0]}, 32'd0);
        check("midop_reset_ops_u0", {16'd0, ops_s[0]}, 32'd0);
        check("midop_reset_ops_u1", {16'd0, ops_s[1]}, 32'd0);
        exp_ops[0] = 0;
        exp_ops[1] = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("post_reset_ops", {16'd0, ops_s[0]}, 32'd0);
        issue(0, 8'd7, 8'h06, 16'd42, 7, 4'd3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
